// File: rtl/lap_recorder.sv
// lap_recorder: captures the running unit count on each rising edge of pause
// into a DEPTH-entry circular buffer, read oldest-first through a pop port.
// A full buffer overwrites its oldest lap and raises a sticky overflow flag.
// Optional feature: define LAP_DELTA_EN to store the difference from the
// previous lap instead of the absolute count.
module lap_recorder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] unit_count,
  input  logic              pause,
  input  logic              clear,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   lap_count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] lap_mem_q [DEPTH];

  logic              pause_d_q,  pause_d_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic              capture;
  logic              do_cap;
  logic              do_pop;
  logic              is_empty;
  logic              is_full;
  logic              mem_we;
  logic [DATA_W-1:0] entry;

`ifdef LAP_DELTA_EN
  logic [DATA_W-1:0] base_q, base_d;

  // Lap entry is the wrap-around distance from the previous captured count
  always_comb begin
    entry  = unit_count - base_q;
    base_d = base_q;
    if (clear) begin
      base_d = '0;
    end else if (do_cap) begin
      base_d = unit_count;
    end
  end

  // Base register holding the count of the most recent capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end
`else
  // Lap entry is the absolute unit count at the capture
  always_comb begin
    entry = unit_count;
  end
`endif

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign capture  = pause & ~pause_d_q;
  assign do_cap   = capture & ~clear;
  assign do_pop   = rd_en & ~is_empty & ~clear;
  assign mem_we   = do_cap;

  // Next-state logic for pointers, fill count, overflow and the read port
  always_comb begin
    pause_d_d  = pause;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_pop) begin
        rd_data_d  = lap_mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end
      if (do_cap) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_cap && !do_pop) begin
        if (is_full) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else if (do_pop && !do_cap) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control and read-port registers, returned to idle by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_d_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      pause_d_q  <= pause_d_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Lap storage; contents are meaningless until written so no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      lap_mem_q[wr_ptr_q] <= entry;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign lap_count = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;

endmodule
